// File: rtl/ascon_serial_collector.sv
// Deserializes the Ascon bit-serial core outputs (text + tag, plus auth flag on
// decryption) into one parallel result per operation on a valid/ready handshake.
// Optional tag comparison is compiled in with `define ASCON_COLLECT_TAG_CHECK_EN.
module ascon_serial_collector #(
  parameter int Y = 80,
  parameter int T = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enc_rdy_i,
  input  logic         ct_bit_i,
  input  logic         tag_bit_i,
  input  logic         dec_rdy_i,
  input  logic         pt_bit_i,
  input  logic         dtag_bit_i,
  input  logic         auth_i,
  input  logic [T-1:0] expected_tag_i,
  input  logic         out_ready_i,
  output logic         out_valid_o,
  output logic         out_dec_o,
  output logic         out_auth_o,
  output logic [Y-1:0] out_text_o,
  output logic [T-1:0] out_tag_o,
  output logic         tag_match_o,
  output logic         busy_o
);

  localparam int CW = $clog2(T);

  typedef enum logic [1:0] {IDLE, CAPTURE, VALID, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;
  logic          auth_q, auth_d;
  logic [Y-1:0]  textSr_q, textSr_d;
  logic [T-1:0]  tagSr_q, tagSr_d;
  logic          valid_q, valid_d;
  logic          dec_q, dec_d;
  logic          authOut_q, authOut_d;
  logic [Y-1:0]  text_q, text_d;
  logic [T-1:0]  tag_q, tag_d;

  logic          selRdy, selText, selTag;
  logic [Y-1:0]  textShift;
  logic [T-1:0]  tagShift;

`ifdef ASCON_COLLECT_TAG_CHECK_EN
  logic match_q, match_d;
  assign tag_match_o = match_q;
`else
  logic unusedExpectedTag;
  assign unusedExpectedTag = ^expected_tag_i;
  assign tag_match_o       = 1'b0;
`endif

  // mode_q = 1 selects the decryption streams and ready level
  assign selRdy  = mode_q ? dec_rdy_i  : enc_rdy_i;
  assign selText = mode_q ? pt_bit_i   : ct_bit_i;
  assign selTag  = mode_q ? dtag_bit_i : tag_bit_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      auth_q    <= 1'b0;
      textSr_q  <= '0;
      tagSr_q   <= '0;
      valid_q   <= 1'b0;
      dec_q     <= 1'b0;
      authOut_q <= 1'b0;
      text_q    <= '0;
      tag_q     <= '0;
`ifdef ASCON_COLLECT_TAG_CHECK_EN
      match_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      auth_q    <= auth_d;
      textSr_q  <= textSr_d;
      tagSr_q   <= tagSr_d;
      valid_q   <= valid_d;
      dec_q     <= dec_d;
      authOut_q <= authOut_d;
      text_q    <= text_d;
      tag_q     <= tag_d;
`ifdef ASCON_COLLECT_TAG_CHECK_EN
      match_q   <= match_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    auth_d    = auth_q;
    textSr_d  = textSr_q;
    tagSr_d   = tagSr_q;
    valid_d   = valid_q;
    dec_d     = dec_q;
    authOut_d = authOut_q;
    text_d    = text_q;
    tag_d     = tag_q;
`ifdef ASCON_COLLECT_TAG_CHECK_EN
    match_d   = match_q;
`endif
    // New bits enter at the MSB so the first serial bit ends up at bit 0
    textShift          = textSr_q >> 1;
    textShift[Y-1]     = selText;
    tagShift           = tagSr_q >> 1;
    tagShift[T-1]      = selTag;

    case (state_q)
      IDLE: begin
        if (enc_rdy_i) begin
          mode_d  = 1'b0;
          auth_d  = 1'b0;
          cnt_d   = '0;
          state_d = CAPTURE;
        end else if (dec_rdy_i) begin
          mode_d  = 1'b1;
          auth_d  = auth_i;
          cnt_d   = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!selRdy) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          if (int'(cnt_q) < Y) textSr_d = textShift;
          tagSr_d = tagShift;
          if (cnt_q == CW'(T - 1)) begin
            cnt_d   = '0;
            state_d = VALID;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      VALID: begin
        // First cycle in VALID publishes the result; later cycles wait for the handshake
        if (!valid_q) begin
          valid_d   = 1'b1;
          dec_d     = mode_q;
          authOut_d = auth_q;
          text_d    = textSr_q;
          tag_d     = tagSr_q;
`ifdef ASCON_COLLECT_TAG_CHECK_EN
          match_d   = (tagSr_q == expected_tag_i);
`endif
        end else if (out_ready_i) begin
          valid_d = 1'b0;
`ifdef ASCON_COLLECT_TAG_CHECK_EN
          match_d = 1'b0;
`endif
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!selRdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid_o = valid_q;
  assign out_dec_o   = dec_q;
  assign out_auth_o  = authOut_q;
  assign out_text_o  = text_q;
  assign out_tag_o   = tag_q;
  assign busy_o      = (state_q == CAPTURE);

endmodule

// File: tb/tb_ascon_serial_collector.sv
// Self-checking bench for ascon_serial_collector: table vectors, random operations,
// abort and mid-operation reset sequences against a stream-level reference model.
module tb_ascon_serial_collector;

  localparam int Y = 80;
  localparam int T = 128;
`ifdef ASCON_COLLECT_TAG_CHECK_EN
  localparam bit MATCH_ON = 1'b1;
`else
  localparam bit MATCH_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         enc_rdy_i, ct_bit_i, tag_bit_i;
  logic         dec_rdy_i, pt_bit_i, dtag_bit_i, auth_i;
  logic [T-1:0] expected_tag_i;
  logic         out_ready_i;
  logic         out_valid_o, out_dec_o, out_auth_o, tag_match_o, busy_o;
  logic [Y-1:0] out_text_o;
  logic [T-1:0] out_tag_o;

  int assertCount = 0;
  int failCount   = 0;
  logic [Y-1:0] lastText;
  logic [T-1:0] lastTag;

  typedef struct {
    bit           isDec;
    bit           both;
    bit           authIn;
    logic [Y-1:0] txt;
    logic [T-1:0] tg;
    bit           flipExp;
    int           hold;
    bit           expDec;
    bit           expAuth;
    bit           expMatch;
  } vec_t;

  vec_t vecs[4];

  ascon_serial_collector #(.Y(Y), .T(T)) dut (
    .clk            (clk),
    .rst            (rst),
    .enc_rdy_i      (enc_rdy_i),
    .ct_bit_i       (ct_bit_i),
    .tag_bit_i      (tag_bit_i),
    .dec_rdy_i      (dec_rdy_i),
    .pt_bit_i       (pt_bit_i),
    .dtag_bit_i     (dtag_bit_i),
    .auth_i         (auth_i),
    .expected_tag_i (expected_tag_i),
    .out_ready_i    (out_ready_i),
    .out_valid_o    (out_valid_o),
    .out_dec_o      (out_dec_o),
    .out_auth_o     (out_auth_o),
    .out_text_o     (out_text_o),
    .out_tag_o      (out_tag_o),
    .tag_match_o    (tag_match_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives serial bit k of the selected stream; the other stream carries noise
  task automatic driveBits(input bit isDec, input int k, input logic [Y-1:0] txt, input logic [T-1:0] tg);
    logic tb, gb;
    tb = (k < Y) ? txt[k] : 1'($urandom);
    gb = tg[k];
    ct_bit_i   = isDec ? 1'($urandom) : tb;
    tag_bit_i  = isDec ? 1'($urandom) : gb;
    pt_bit_i   = isDec ? tb : 1'($urandom);
    dtag_bit_i = isDec ? gb : 1'($urandom);
    auth_i     = 1'($urandom);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [T-1:0] expTag;
    bit           encSide;
    encSide = !v.isDec || v.both;
    expTag  = v.tg;
    if (v.flipExp) expTag[T-1] = ~expTag[T-1];
    expected_tag_i = expTag;
    enc_rdy_i = !v.isDec || v.both;
    dec_rdy_i = v.isDec || v.both;
    auth_i    = v.authIn;
    tick();
    checkOutput("busyAtStart", busy_o, 1);
    for (int k = 0; k < T; k++) begin
      driveBits(!encSide, k, v.txt, v.tg);
      tick();
      checkOutput("validEarly", out_valid_o, 0);
    end
    checkOutput("busyAfterLastBit", busy_o, 0);
    tick();
    checkOutput("validRise", out_valid_o, 1);
    checkOutput("outDec", out_dec_o, v.expDec);
    checkOutput("outAuth", out_auth_o, v.expAuth);
    checkOutput("outText", out_text_o, v.txt);
    checkOutput("outTag", out_tag_o, v.tg);
    checkOutput("tagMatch", tag_match_o, v.expMatch);
    for (int i = 0; i < 10; i++) begin
      driveBits(!encSide, i, v.txt, v.tg);
      tick();
      checkOutput("validHeld", out_valid_o, 1);
      checkOutput("textHeld", out_text_o, v.txt);
      checkOutput("tagHeld", out_tag_o, v.tg);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    checkOutput("validAfterAccept", out_valid_o, 0);
    checkOutput("matchAfterAccept", tag_match_o, 0);
    checkOutput("textAfterAccept", out_text_o, v.txt);
    for (int i = 0; i < v.hold; i++) begin
      tick();
      checkOutput("noRetrigger", out_valid_o | busy_o, 0);
    end
    enc_rdy_i = 1'b0;
    dec_rdy_i = 1'b0;
    tick();
    tick();
    checkOutput("idleAfterDrain", busy_o, 0);
    lastText = v.txt;
    lastTag  = v.tg;
  endtask

  function automatic vec_t randomVec();
    vec_t v;
    logic [95:0]  t96;
    t96        = {$urandom, $urandom, $urandom};
    v.isDec    = 1'($urandom);
    v.both     = ($urandom_range(0, 3) == 0);
    v.authIn   = 1'($urandom);
    v.txt      = t96[Y-1:0];
    v.tg       = {$urandom, $urandom, $urandom, $urandom};
    v.flipExp  = 1'($urandom);
    v.hold     = 3;
    v.expDec   = v.isDec && !v.both;
    v.expAuth  = v.expDec && v.authIn;
    v.expMatch = MATCH_ON && !v.flipExp;
    return v;
  endfunction

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 80'hA5A5_0123_4567_89AB_CDEF,
                128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0, 0, 1'b0, 1'b0, MATCH_ON};
    vecs[1] = '{1'b1, 1'b0, 1'b0, {Y{1'b1}},
                128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b1, 50, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 80'h1234_5678_9ABC_DEF0_1357,
                128'h80000000_00000000_00000000_00000001, 1'b0, 5, 1'b0, 1'b0, MATCH_ON};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 80'hDEAD_BEEF_0000_FFFF_8001,
                128'hCAFEBABE_DEADBEEF_00112233_44556677, 1'b0, 0, 1'b1, 1'b1, MATCH_ON};

    rst = 1'b1;
    enc_rdy_i = 1'b0; dec_rdy_i = 1'b0;
    ct_bit_i = 1'b0; tag_bit_i = 1'b0; pt_bit_i = 1'b0; dtag_bit_i = 1'b0;
    auth_i = 1'b0; out_ready_i = 1'b0; expected_tag_i = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("resetValid", out_valid_o, 0);
    checkOutput("resetText", out_text_o, 0);
    checkOutput("resetTag", out_tag_o, 0);
    checkOutput("resetFlags", {out_dec_o, out_auth_o, tag_match_o, busy_o}, 0);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);
    for (int i = 0; i < 3; i++) applyStimulus(randomVec());

    // Ready level drops at bit 40: capture aborts, previous result survives
    enc_rdy_i = 1'b1;
    tick();
    for (int k = 0; k < 40; k++) begin
      driveBits(1'b0, k, {Y{1'b0}}, {T{1'b0}});
      tick();
    end
    enc_rdy_i = 1'b0;
    tick();
    checkOutput("abortBusy", busy_o, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("abortNoValid", out_valid_o, 0);
    end
    checkOutput("abortKeepsText", out_text_o, lastText);
    checkOutput("abortKeepsTag", out_tag_o, lastTag);
    applyStimulus(randomVec());

    // Reset at bit 100 of a decryption, then a fresh operation
    dec_rdy_i = 1'b1;
    auth_i    = 1'b1;
    tick();
    for (int k = 0; k < 100; k++) begin
      driveBits(1'b1, k, {Y{1'b1}}, {T{1'b1}});
      tick();
    end
    rst = 1'b1;
    dec_rdy_i = 1'b0;
    tick();
    rst = 1'b0;
    checkOutput("midResetValid", out_valid_o, 0);
    checkOutput("midResetText", out_text_o, 0);
    checkOutput("midResetTag", out_tag_o, 0);
    checkOutput("midResetFlags", {out_dec_o, out_auth_o, tag_match_o, busy_o}, 0);
    applyStimulus(vecs[3]);
    applyStimulus(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/ascon_serial_collector.md
Name: ascon_serial_collector

Overview:
- Sits directly downstream of the Ascon bit-serial core.
- Deserializes the core's LSB-first serial outputs into parallel words:
  - encryption: cipher text + tag
  - decryption: plain text + tag + authentication flag
- Presents one result per operation on a valid/ready handshake to the host-side register interface.

Parameters:
Y, 80, message length in bits (cipher/plain text); legal range 1..128
T, 128, tag length in bits; fixed 128, bit counter sized for it

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
enc_rdy_i  input  1  encryption-ready level from core
ct_bit_i  input  1  serial cipher-text bit
tag_bit_i  input  1  serial encryption tag bit
dec_rdy_i  input  1  decryption-ready level from core
pt_bit_i  input  1  serial decrypted plain-text bit
dtag_bit_i  input  1  serial decryption tag bit
auth_i  input  1  message-authentication flag from core
expected_tag_i  input  T  reference tag for optional check
out_ready_i  input  1  consumer accepts result
out_valid_o  output  1  result held stable
out_dec_o  output  1  0 = encryption result, 1 = decryption result
out_auth_o  output  1  latched auth flag (decryption only, else 0)
out_text_o  output  Y  collected text, bit k = k-th serial bit
out_tag_o  output  T  collected tag, bit k = k-th serial bit
tag_match_o  output  1  optional tag-compare result
busy_o  output  1  high in CAPTURE

Behaviour:
- Reset: all outputs 0, state IDLE, bit counter 0, shift registers 0.
- State IDLE:
  - On an edge with enc_rdy_i=1: latch mode enc, go CAPTURE, counter=0.
  - Else on dec_rdy_i=1: latch mode dec, latch auth_i, go CAPTURE.
  - Both high same edge: encryption wins.
- Alignment: the core registers bit k one cycle after its ready goes high. So the first edge that sees ready is C0, and bit k is sampled at edge C0+1+k, k=0..T-1.
- State CAPTURE:
  - Each edge: sample the mode-selected text and tag bits.
  - Text: shift in at MSB, shift right, only while counter<Y. After Y samples, text bit 0 sits at LSB.
  - Tag: same scheme for all T samples.
  - At counter==T-1 the sample is taken, out_valid_o=1 next cycle, state VALID.
  - Total latency: out_valid_o rises at edge C0+1+T (129 cycles after C0).
- State VALID:
  - Outputs held stable while out_ready_i=0.
  - On an edge with out_valid_o & out_ready_i: out_valid_o←0, go DRAIN.
- State DRAIN: wait until the latched mode's ready input is 0, then IDLE. A held-high level from the core therefore never retriggers.
- Ready level dropping during CAPTURE:
  - Abort capture; no valid is produced.
  - Go IDLE with counter cleared.
  - Partial data is discarded (out_text_o/out_tag_o keep the previous result).
- Other-mode ready rising during CAPTURE/VALID/DRAIN: ignored.
- out_auth_o: latched from auth_i at C0; forced 0 for encryption.
- Reset mid-operation: immediate return to reset values; an in-flight result is lost.
- busy_o=1 exactly in CAPTURE.

Optional Feature:
ASCON_COLLECT_TAG_CHECK_EN
- Defined:
  - When entering VALID, register tag_match_o = (collected tag == expected_tag_i).
  - Held with out_valid_o; cleared on handshake.
- Undefined:
  - tag_match_o is constant 0.
  - expected_tag_i is unused; no comparator is synthesized.

Test Plan:
1. Reset, then enc_rdy_i high at C0; drive ct bits of 80'hA5A5_0123_4567_89AB_CDEF (LSB first) and tag 128'h0F0E…00 from C0+1; hold out_ready_i=0.
   -> out_valid_o at C0+129; out_text_o/out_tag_o match exactly; out_dec_o=0.
   -> outputs stable for 10 cycles, then accepted on out_ready_i=1.
2. dec_rdy_i with auth_i=0, pt stream all-ones.
   -> out_dec_o=1, out_auth_o=0, out_text_o=80'hFF…FF.
   -> after handshake, ready held high 50 cycles: no second out_valid_o.
3. enc_rdy_i and dec_rdy_i rise on the same edge.
   -> encryption stream captured, out_dec_o=0.
4. enc_rdy_i drops at bit 40.
   -> no out_valid_o; busy_o falls; next full operation is captured correctly.
5. rst asserted at bit 100, then a new operation.
   -> all outputs 0 after the reset edge; new result is correct.
6. With ASCON_COLLECT_TAG_CHECK_EN: matching expected_tag_i -> tag_match_o=1; one flipped bit (bit 127) -> 0. Without the macro -> always 0.
